matrix_slot_manager: RTL
========================

# matrix_slot_manager

Owns the matrix storage address space: a pool of fixed-size slots, with one stored matrix per slot. Serves the input path's dimension/base-address handshake by allocating a slot and returning its base address. Commits or releases that slot when input finishes or fails. Also resolves user-entered matrix IDs to base address and dimensions for the compute and display paths. Sits between the top-level FSM, the input subsystem and the storage write MUX.

## Interface
Parameters:
- NUM_SLOTS, 10, number of matrix slots
- SLOT_WORDS, 25, words per slot (5x5 maximum)
- ADDR_W, 8, storage address width; NUM_SLOTS*SLOT_WORDS <= 2**ADDR_W, checked at elaboration

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- alloc_req  in  1  level request (driven by input dims_valid); held until alloc_ready seen
- alloc_m, alloc_n  in  3 each  requested dimensions, 1..5
- alloc_ready  out  1  one-cycle grant pulse (drives input addr_ready)
- alloc_base  out  ADDR_W  base address of granted slot; stable from grant until commit/abort
- alloc_slot  out  4  granted slot index
- commit  in  1  input finished (rx_done); validates reserved slot
- abort  in  1  input error or disable; releases reservation
- lookup_req  in  1  one-cycle ID lookup request
- lookup_id  in  4  1-based slot ID
- lookup_done  out  1  one-cycle result strobe
- lookup_hit  out  1  ID names a valid slot
- lookup_base  out  ADDR_W; lookup_m, lookup_n  out  3 each  result fields
- busy  out  1  not in IDLE
- valid_count  out  4  number of valid slots (see Configuration)

## Operation
- Per-slot table holds valid, m, n. Reset clears all valid bits. victim_ptr resets to 0.
- States: IDLE, SCAN, GRANT, HOLD, LOOKUP.
- IDLE: alloc_req=1 goes to SCAN, with idx=0 and base_acc=0. Otherwise lookup_req=1 goes to LOOKUP. alloc has priority when both arrive together; the lookup is dropped and no lookup_done is produced.
- Requests with alloc_m or alloc_n outside 1..5 are ignored. FSM stays in IDLE.
- SCAN: visits one slot per cycle and increments base_acc by SLOT_WORDS (no multiplier).
  - Stops at the first invalid slot.
  - If none are invalid after idx=NUM_SLOTS-1, selects victim_ptr and sets evict=1. base is then victim_ptr*SLOT_WORDS, computed by the same accumulation with the scan continuing to victim_ptr.
- GRANT: registers alloc_base and alloc_slot, pulses alloc_ready, then goes to HOLD.
- HOLD: waits for commit or abort. abort wins when both are asserted.
  - commit: valid=1, stores m and n. If evict=1, victim_ptr advances and wraps from NUM_SLOTS-1 to 0.
  - abort: slot valid=0. An evicted victim is therefore lost, since its data may already be cleared. victim_ptr advances if evict=1.
  - Either outcome returns to IDLE.
- alloc_req still high on return to IDLE starts a new allocation. The input side drops the request after ready.
- LOOKUP: id 0, id > NUM_SLOTS, or an invalid slot gives hit=0 with base, m and n forced to 0. Otherwise hit=1 with the stored fields. Returns to IDLE.
- Base width: slot*SLOT_WORDS is truncated to ADDR_W; the elaboration check guarantees no overflow.

## Timing
- Reset values of all outputs are 0.
- Allocation latency, with alloc_req sampled high in IDLE at cycle 0:
  - first free slot at index k: alloc_ready at cycle k+2;
  - table full: alloc_ready at cycle NUM_SLOTS+victim_ptr+2 at most.
- Commit and abort are sampled only in HOLD and ignored elsewhere. Table update is visible to a lookup accepted on the next cycle.
- Lookup: lookup_done two cycles after lookup_req is sampled in IDLE. lookup_req is ignored while busy.
- rst mid-operation: returns to IDLE, invalidates all slots, and drops any pending grant or lookup in the same cycle.

## Configuration
- SLOT_COUNT_EN defined: valid_count tracks the number of valid slots, incremented on commit of a non-evicting allocation and decremented on abort of an evicting one.
- SLOT_COUNT_EN undefined: valid_count is tied to 0 and its counter is not built.

## Structure
- Shared package matrix_pkg holds the state enum, MAX_DIM=5, SLOT_WORDS default, and the slot record type (valid, m, n).
- One sub-module, slot_table: NUM_SLOTS-entry register file with one write port (commit/invalidate) and two combinational read ports (scan index, lookup index).

## Test plan
- After rst, request 2x3 -> alloc_ready at cycle 2, base=0, slot=0; commit -> lookup id 1 gives hit=1, m=2, n=3, base=0.
- Fill slots 0..3, abort slot 1, request 4x4 -> grant slot 1, base=25, latency 3 cycles.
- Commit all 10 slots, then request 1x1 -> evicts slot 0, base=0, victim_ptr=1; next full request -> slot 1, base=25.
- Evicting grant followed by abort -> lookup of the victim ID gives hit=0; with SLOT_COUNT_EN, valid_count=9.
- Same-cycle alloc_req and lookup_req -> only alloc proceeds, no lookup_done; commit and abort together -> slot ends invalid.
- lookup_id 0 and 11 -> hit=0, base=0; rst asserted in HOLD -> all lookups miss afterwards and busy=0 the next cycle.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and constants for the matrix slot manager.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matrix_pkg;

  localparam int MAX_DIM             = 5;
  localparam int SLOT_WORDS_DEFAULT  = 25;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_GRANT  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_LOOKUP = 3'd4
  } state_t;

  // One stored matrix: occupancy flag plus its dimensions.
  typedef struct packed {
    logic       valid;
    logic [2:0] m;
    logic [2:0] n;
  } slot_rec_t;

  // Both dimensions must lie in 1..MAX_DIM for an allocation to be accepted.
  function automatic logic dims_ok(input logic [2:0] m, input logic [2:0] n);
    return (m >= 3'd1) && (m <= 3'(MAX_DIM)) && (n >= 3'd1) && (n <= 3'(MAX_DIM));
  endfunction

endpackage

// File: rtl/matrix_slot_manager_slot_table.sv
// Slot record register file: one write port, two combinational read ports.
// Latency: writes visible the cycle after i_wr_en; reads are combinational.
// Backpressure: none; every write is accepted.
// Ports: clk/rst (sync, active-high, clears all records); i_wr_en/i_wr_idx/i_wr_rec
// write port; i_rd_a_idx -> o_rd_a_valid (scan, occupancy only);
// i_rd_b_idx -> o_rd_b_rec (lookup, full record). Out-of-range reads return 0.
module slot_table
  import matrix_pkg::*;
#(
  parameter int NUM_SLOTS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr_en,
  input  logic [3:0] i_wr_idx,
  input  slot_rec_t  i_wr_rec,
  input  logic [3:0] i_rd_a_idx,
  output logic       o_rd_a_valid,
  input  logic [3:0] i_rd_b_idx,
  output slot_rec_t  o_rd_b_rec
);

  localparam logic [3:0] LP_N = 4'(NUM_SLOTS);

  slot_rec_t r_tbl [NUM_SLOTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (i_wr_en && (i_wr_idx < LP_N)) begin
      r_tbl[i_wr_idx] <= i_wr_rec;
    end
  end

  assign o_rd_a_valid = (i_rd_a_idx < LP_N) ? r_tbl[i_rd_a_idx].valid : 1'b0;
  assign o_rd_b_rec   = (i_rd_b_idx < LP_N) ? r_tbl[i_rd_b_idx] : '0;

endmodule

// File: rtl/matrix_slot_manager.sv
// Matrix storage slot allocator (scan for free slot, FIFO-style eviction when full)
// and matrix-ID lookup. Latency: grant k+2 cycles for first free slot k, at most
// NUM_SLOTS+victim_ptr+2 when full; lookup result 2 cycles after request.
// Backpressure: alloc_req is a held level until alloc_ready; lookup_req ignored while busy.
// Ports: clk, rst (sync active-high); alloc_req/alloc_m/alloc_n -> alloc_ready/
// alloc_base/alloc_slot; commit/abort close the reservation; lookup_req/lookup_id ->
// lookup_done/lookup_hit/lookup_base/lookup_m/lookup_n; busy; valid_count.
// Optional feature macro: SLOT_COUNT_EN (valid-slot counter; otherwise valid_count = 0).
module matrix_slot_manager
  import matrix_pkg::*;
#(
  parameter int NUM_SLOTS  = 10,
  parameter int SLOT_WORDS = SLOT_WORDS_DEFAULT,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  input  logic [2:0]        alloc_m,
  input  logic [2:0]        alloc_n,
  output logic              alloc_ready,
  output logic [ADDR_W-1:0] alloc_base,
  output logic [3:0]        alloc_slot,
  input  logic              commit,
  input  logic              abort,
  input  logic              lookup_req,
  input  logic [3:0]        lookup_id,
  output logic              lookup_done,
  output logic              lookup_hit,
  output logic [ADDR_W-1:0] lookup_base,
  output logic [2:0]        lookup_m,
  output logic [2:0]        lookup_n,
  output logic              busy,
  output logic [3:0]        valid_count
);

  if (NUM_SLOTS * SLOT_WORDS > (2 ** ADDR_W)) begin : g_addr_chk
    $error("matrix_slot_manager: NUM_SLOTS*SLOT_WORDS exceeds 2**ADDR_W");
  end
  if (NUM_SLOTS < 1 || NUM_SLOTS > 15) begin : g_slot_chk
    $error("matrix_slot_manager: NUM_SLOTS must be 1..15");
  end

  localparam logic [3:0]        LP_LAST = 4'(NUM_SLOTS - 1);
  localparam logic [3:0]        LP_N    = 4'(NUM_SLOTS);
  localparam logic [ADDR_W-1:0] LP_SW   = ADDR_W'(SLOT_WORDS);

  state_t            r_state;
  logic [3:0]        r_idx;
  logic [ADDR_W-1:0] r_base_acc;
  logic              r_evict;
  logic [3:0]        r_victim_ptr;
  logic [2:0]        r_req_m;
  logic [2:0]        r_req_n;
  logic [3:0]        r_lk_id;
  logic              r_alloc_ready;
  logic [ADDR_W-1:0] r_alloc_base;
  logic [3:0]        r_alloc_slot;
  logic              r_lookup_done;
  logic              r_lookup_hit;
  logic [ADDR_W-1:0] r_lookup_base;
  logic [2:0]        r_lookup_m;
  logic [2:0]        r_lookup_n;

  logic              w_scan_valid;
  slot_rec_t         w_lk_rec;
  logic [3:0]        w_lk_idx;
  logic              w_lk_hit;
  logic [ADDR_W-1:0] w_lk_base;
  logic              w_alloc_go;
  logic              w_hold_commit;
  logic              w_hold_abort;
  logic              w_wr_en;
  slot_rec_t         w_wr_rec;

  // abort wins over a simultaneous commit
  assign w_hold_abort  = (r_state == ST_HOLD) && abort;
  assign w_hold_commit = (r_state == ST_HOLD) && commit && !abort;
  assign w_wr_en       = w_hold_abort || w_hold_commit;
  assign w_wr_rec      = w_hold_commit ? '{valid: 1'b1, m: r_req_m, n: r_req_n} : '0;

  assign w_alloc_go = alloc_req && dims_ok(alloc_m, alloc_n);

  // IDs are 1-based; id 0 wraps to 15 and reads back as an empty record.
  assign w_lk_idx  = r_lk_id - 4'd1;
  assign w_lk_hit  = (r_lk_id != 4'd0) && (r_lk_id <= LP_N) && w_lk_rec.valid;
  assign w_lk_base = ADDR_W'(int'(w_lk_idx) * SLOT_WORDS);

  slot_table #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_table (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (w_wr_en),
    .i_wr_idx     (r_alloc_slot),
    .i_wr_rec     (w_wr_rec),
    .i_rd_a_idx   (r_idx),
    .o_rd_a_valid (w_scan_valid),
    .i_rd_b_idx   (w_lk_idx),
    .o_rd_b_rec   (w_lk_rec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_idx         <= '0;
      r_base_acc    <= '0;
      r_evict       <= 1'b0;
      r_victim_ptr  <= '0;
      r_req_m       <= '0;
      r_req_n       <= '0;
      r_lk_id       <= '0;
      r_alloc_ready <= 1'b0;
      r_alloc_base  <= '0;
      r_alloc_slot  <= '0;
      r_lookup_done <= 1'b0;
      r_lookup_hit  <= 1'b0;
      r_lookup_base <= '0;
      r_lookup_m    <= '0;
      r_lookup_n    <= '0;
    end else begin
      r_lookup_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_alloc_go) begin
            r_state    <= ST_SCAN;
            r_idx      <= '0;
            r_base_acc <= '0;
            r_evict    <= 1'b0;
            r_req_m    <= alloc_m;
            r_req_n    <= alloc_n;
          end else if (lookup_req) begin
            r_state <= ST_LOOKUP;
            r_lk_id <= lookup_id;
          end
        end

        ST_SCAN: begin
          // Grant outputs are loaded on the way into GRANT so the ready pulse
          // lands exactly k+2 cycles after the request was sampled.
          if ((!r_evict && !w_scan_valid) || (r_evict && (r_idx == r_victim_ptr))) begin
            r_state       <= ST_GRANT;
            r_alloc_base  <= r_base_acc;
            r_alloc_slot  <= r_idx;
            r_alloc_ready <= 1'b1;
          end else if (!r_evict && (r_idx == LP_LAST)) begin
            // Table full: rescan from 0 up to the victim so its base is
            // produced by the same adder chain.
            r_evict    <= 1'b1;
            r_idx      <= '0;
            r_base_acc <= '0;
          end else begin
            r_idx      <= r_idx + 4'd1;
            r_base_acc <= r_base_acc + LP_SW;
          end
        end

        ST_GRANT: begin
          r_alloc_ready <= 1'b0;
          r_state       <= ST_HOLD;
        end

        ST_HOLD: begin
          if (w_hold_abort || w_hold_commit) begin
            if (r_evict) begin
              r_victim_ptr <= (r_victim_ptr == LP_LAST) ? 4'd0 : r_victim_ptr + 4'd1;
            end
            r_state <= ST_IDLE;
          end
        end

        ST_LOOKUP: begin
          r_lookup_done <= 1'b1;
          r_lookup_hit  <= w_lk_hit;
          r_lookup_base <= w_lk_hit ? w_lk_base  : '0;
          r_lookup_m    <= w_lk_hit ? w_lk_rec.m : '0;
          r_lookup_n    <= w_lk_hit ? w_lk_rec.n : '0;
          r_state       <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SLOT_COUNT_EN
  logic [3:0] r_valid_count;

  // Only a fresh slot filled or a victim dropped changes occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_count <= '0;
    end else if (w_hold_commit && !r_evict) begin
      r_valid_count <= r_valid_count + 4'd1;
    end else if (w_hold_abort && r_evict) begin
      r_valid_count <= r_valid_count - 4'd1;
    end
  end

  assign valid_count = r_valid_count;
`else
  assign valid_count = 4'd0;
`endif

  assign alloc_ready = r_alloc_ready;
  assign alloc_base  = r_alloc_base;
  assign alloc_slot  = r_alloc_slot;
  assign lookup_done = r_lookup_done;
  assign lookup_hit  = r_lookup_hit;
  assign lookup_base = r_lookup_base;
  assign lookup_m    = r_lookup_m;
  assign lookup_n    = r_lookup_n;
  assign busy        = (r_state != ST_IDLE);

endmodule
